// File: rtl/control_sumador_serie.sv
// ---------------------------------------------------------------------------
// control_sumador_serie
// Bit-serial adder controller: adds two ANCHO-bit operands LSB-first, one bit
// per clock, through a single 1-bit full-adder cell built from two half adders.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active-high
//   inicio   in   start request, sampled only while idle
//   A, B     in   operands, latched when a start is accepted
//   Ce       in   carry-in, latched when a start is accepted
//   S        out  registered sum, holds until the next completion
//   Cs       out  registered carry-out, holds until the next completion
//   ocupado  out  registered, high while an operation is in progress
//   listo    out  registered, one-cycle done pulse (S/Cs valid)
// ---------------------------------------------------------------------------

// 1-bit half adder
module medio_sumador (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// 1-bit full adder from two half adders and an OR
module sumador_completo (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic s1;
   logic c1;
   logic c2;

   medio_sumador u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
   medio_sumador u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

   assign co = c1 | c2;
endmodule

module control_sumador_serie #(
   parameter  int unsigned ANCHO = 8,
   localparam int unsigned CNT_W = $clog2(ANCHO)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inicio,
   input  logic [ANCHO-1:0] A,
   input  logic [ANCHO-1:0] B,
   input  logic             Ce,
   output logic [ANCHO-1:0] S,
   output logic             Cs,
   output logic             ocupado,
   output logic             listo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUMA = 2'd1,
      FIN  = 2'd2
   } estado_t;

   estado_t          estado;
   estado_t          estado_sig;

   logic [ANCHO-1:0] ra;
   logic [ANCHO-1:0] rb;
   logic [ANCHO-1:0] rs;
   logic             c;
   logic [CNT_W-1:0] cnt;

   logic             s_bit;
   logic             c_next;
   logic             ultimo;
   logic             acepta;
   logic             avanza;
   logic             ocupado_d;
   logic             listo_d;

   // Serial arithmetic cell working on the current LSBs and stored carry
   sumador_completo u_fa (
      .a  (ra[0]),
      .b  (rb[0]),
      .ci (c),
      .s  (s_bit),
      .co (c_next)
   );

   assign ultimo = (cnt == CNT_W'(ANCHO - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         estado <= IDLE;
      end else begin
         estado <= estado_sig;
      end
   end

   // Next-state and control decode
   always_comb begin
      estado_sig = estado;
      acepta     = 1'b0;
      avanza     = 1'b0;
      case (estado)
         IDLE: begin
            if (inicio) begin
               acepta     = 1'b1;
               estado_sig = SUMA;
            end
         end
         SUMA: begin
            avanza = 1'b1;
            if (ultimo) begin
               estado_sig = FIN;
            end
         end
         FIN: begin
            estado_sig = IDLE;
         end
         default: begin
            estado_sig = IDLE;
         end
      endcase
      // Status flags are registered from the state being entered
      ocupado_d = (estado_sig != IDLE);
      listo_d   = (estado_sig == FIN);
   end

   // Datapath: operand/result shift registers, carry, bit counter, outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         ra      <= '0;
         rb      <= '0;
         rs      <= '0;
         c       <= 1'b0;
         cnt     <= '0;
         S       <= '0;
         Cs      <= 1'b0;
         ocupado <= 1'b0;
         listo   <= 1'b0;
      end else begin
         ocupado <= ocupado_d;
         listo   <= listo_d;
         if (acepta) begin
            ra  <= A;
            rb  <= B;
            c   <= Ce;
            cnt <= '0;
         end else if (avanza) begin
            ra <= {1'b0, ra[ANCHO-1:1]};
            rb <= {1'b0, rb[ANCHO-1:1]};
            rs <= {s_bit, rs[ANCHO-1:1]};
            c  <= c_next;
            // Counter holds on the last bit so it never wraps
            if (!ultimo) begin
               cnt <= cnt + CNT_W'(1);
            end else begin
               S  <= {s_bit, rs[ANCHO-1:1]};
               Cs <= c_next;
            end
         end
      end
   end

endmodule
